// File: rtl/packet_chopper_pkg.sv
// Shared types and sizing helpers for the packet chopper front-end arbiter.
// The timeout logic in the arbiter is enabled by defining PKT_ARB_TIMEOUT_EN.
package packet_chopper_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PASS  = 2'd1,
        ARB_FLUSH = 2'd2
    } arbState_t;

    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cntWidth(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

    // Default stall limit and the counter width it needs.
    localparam int unsigned ARB_TIMEOUT_CYCLES = 1024;
    localparam int unsigned ARB_TO_CNT_W       = $clog2(ARB_TIMEOUT_CYCLES + 1);

endpackage

// File: rtl/packet_stream_arbiter_rr_picker.sv
// Combinational round-robin search: first requester after ptr, wrapping modulo NUM_SRC.
module rr_picker #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] candIdx;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        candIdx = '0;
        for (int unsigned off = 1; off <= NUM_SRC; off++) begin
            candIdx = IDX_W'((32'(ptr) + off) % NUM_SRC);
            if (!found && req[candIdx]) begin
                found = 1'b1;
                idx   = candIdx;
            end
        end
    end

endmodule

// File: rtl/packet_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the packet chopper input bus.
// Define PKT_ARB_TIMEOUT_EN to add the stall counter and FLUSH state.
module packet_stream_arbiter
    import packet_chopper_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic [NUM_SRC-1:0]                Src_Val,
    input  logic [NUM_SRC-1:0]                Src_Sop,
    input  logic [NUM_SRC-1:0]                Src_Eop,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]   Src_Mod,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     Src_Dat,
    output logic [NUM_SRC-1:0]                Src_Rdy,
    output logic                              Out_Val,
    output logic                              Out_Sop,
    output logic                              Out_Eop,
    output logic [DATA_WIDTH/8-1:0]           Out_Mod,
    output logic [DATA_WIDTH-1:0]             Out_Dat,
    input  logic                              Out_Rdy,
    output logic [idxWidth(NUM_SRC)-1:0]      Grant_Id,
    output logic                              Busy,
    output logic                              Error
);

    localparam int unsigned MOD_W = DATA_WIDTH / 8;
    localparam int unsigned GW    = idxWidth(NUM_SRC);

    arbState_t state, stateNxt;

    logic [GW-1:0]         ptr;
    logic [GW-1:0]         winIdx;
    logic                  winFound;
    logic                  firstBeat;
    logic                  free;
    logic                  accept;
    logic                  strayErr;
    logic                  seqErr;
    logic                  flushLoad;
    logic [NUM_SRC-1:0]    srcRdy;
    logic [DATA_WIDTH-1:0] srcDat [NUM_SRC];
    logic [MOD_W-1:0]      srcMod [NUM_SRC];

    assign free = !Out_Val || Out_Rdy;

    always_comb begin
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            srcDat[s] = Src_Dat[s*DATA_WIDTH +: DATA_WIDTH];
            srcMod[s] = Src_Mod[s*MOD_W +: MOD_W];
        end
    end

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (GW)
    ) uPicker (
        .req   (Src_Val & Src_Sop),
        .ptr   (ptr),
        .found (winFound),
        .idx   (winIdx)
    );

`ifdef PKT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = cntWidth(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stallCnt;
    logic             stallHit;

    // Trips on the idle cycle that brings the count up to TIMEOUT_CYCLES.
    assign stallHit = (state == ARB_PASS) && !Src_Val[Grant_Id]
                   && (stallCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                                      stallCnt <= '0;
        else if (accept || state != ARB_PASS)         stallCnt <= '0;
        else if (!Src_Val[Grant_Id])                  stallCnt <= stallCnt + 1'b1;
    end
`endif

    always_comb begin
        stateNxt  = state;
        srcRdy    = '0;
        accept    = 1'b0;
        strayErr  = 1'b0;
        flushLoad = 1'b0;
        case (state)
            ARB_IDLE: begin
                srcRdy   = Src_Val & ~Src_Sop;
                strayErr = |srcRdy;
                if (winFound) stateNxt = ARB_PASS;
            end
            ARB_PASS: begin
                srcRdy[Grant_Id] = free;
                accept           = Src_Val[Grant_Id] && free;
                if (accept && Src_Eop[Grant_Id]) stateNxt = ARB_IDLE;
`ifdef PKT_ARB_TIMEOUT_EN
                else if (stallHit)               stateNxt = ARB_FLUSH;
`endif
            end
`ifdef PKT_ARB_TIMEOUT_EN
            ARB_FLUSH: begin
                flushLoad = free;
                if (free) stateNxt = ARB_IDLE;
            end
`endif
            default: stateNxt = ARB_IDLE;
        endcase
    end

    assign seqErr  = accept && Src_Sop[Grant_Id] && !firstBeat;
    assign Src_Rdy = Rst ? '0 : srcRdy;
    assign Busy    = (state != ARB_IDLE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= ARB_IDLE;
            ptr       <= GW'(NUM_SRC - 1);
            Grant_Id  <= '0;
            firstBeat <= 1'b0;
            Error     <= 1'b0;
            Out_Val   <= 1'b0;
            Out_Sop   <= 1'b0;
            Out_Eop   <= 1'b0;
            Out_Mod   <= '0;
            Out_Dat   <= '0;
        end else begin
            state <= stateNxt;
            Error <= strayErr || seqErr || flushLoad;
            if (state == ARB_IDLE && winFound) begin
                Grant_Id  <= winIdx;
                ptr       <= winIdx;
                firstBeat <= 1'b1;
            end else if (accept) begin
                firstBeat <= 1'b0;
            end
            if (free) begin
                if (accept) begin
                    Out_Val <= 1'b1;
                    Out_Sop <= Src_Sop[Grant_Id];
                    Out_Eop <= Src_Eop[Grant_Id];
                    Out_Mod <= srcMod[Grant_Id];
                    Out_Dat <= srcDat[Grant_Id];
                end else if (flushLoad) begin
                    Out_Val <= 1'b1;
                    Out_Sop <= 1'b0;
                    Out_Eop <= 1'b1;
                    Out_Mod <= '0;
                    Out_Dat <= '0;
                end else begin
                    Out_Val <= 1'b0;
                end
            end
        end
    end

endmodule
